zero_one_acc: RTL

ZERO_ONE_ACC -- requirements
Module: zero_one_acc

---
 rtl/zero_one_acc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/zero_one_acc.sv
// zero_one_acc: per-word zero/one counter with per-frame running totals.
//
// Each accepted word (in_valid=1, clear=0) produces registered zero/one
// counts one cycle later and is folded into the frame totals. A word that
// arrives while no frame is open (IDLE or DONE) starts a new frame; a word
// with frame_last=1 closes the frame, and frame_done pulses in the
// following cycle. Totals and word_cnt hold after the frame closes until
// the next frame opens, a clear, or a reset.
//
// Build option:
//   ZERO_ONE_ACC_SAT_EN  defined   -> zeros_total, ones_total, word_cnt
//                                     saturate at all-ones on overflow
//                        undefined -> those values wrap modulo 2^width
// The sticky ovf flag behaves the same in both builds.

module zero_one_acc #(
  parameter  int COUNT_OF_BITS = 4,
  parameter  int ACC_WIDTH     = 16,
  parameter  int CNT_WIDTH     = 8,
  localparam int PW            = $clog2(COUNT_OF_BITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [COUNT_OF_BITS-1:0] num,
  input  logic                     frame_last,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [PW-1:0]            zeros,
  output logic [PW-1:0]            ones,
  output logic [ACC_WIDTH-1:0]     zeros_total,
  output logic [ACC_WIDTH-1:0]     ones_total,
  output logic [CNT_WIDTH-1:0]     word_cnt,
  output logic                     frame_done,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Sum width: wide enough for either operand plus a carry, so the
  // overflow test is an exact compare against 2^ACC_WIDTH.
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
  localparam logic [SW-1:0] ACC_LIM = SW'(1) << ACC_WIDTH;

  state_t state, state_nxt;

  logic                 open_frame;
  logic [PW-1:0]        ones_c, zeros_c;
  logic [SW-1:0]        zsum, osum;
  logic                 z_of, o_of, wc_of;
  logic [ACC_WIDTH-1:0] zt_nxt, ot_nxt;
  logic [CNT_WIDTH-1:0] wc_nxt;
  logic                 ovf_nxt;

  // State register: the only place the frame state changes.
  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples pre-edge values, independent of
  // the order in which always blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: clear wins, any accepted word opens/continues or
  // closes a frame, and DONE falls back to IDLE on an empty cycle.
  // NOTE: every always_comb target gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else if (in_valid) begin
      state_nxt = frame_last ? S_DONE : S_ACCUM;
    end else if (state == S_DONE) begin
      state_nxt = S_IDLE;
    end
  end

  // Datapath next values: per-word counts over every bit of num, the
  // candidate totals, and the overflow conditions for this word.
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < COUNT_OF_BITS; i++) begin
      ones_c = ones_c + PW'(num[i]);
    end
    zeros_c = PW'(COUNT_OF_BITS) - ones_c;

    // Only an open frame (ACCUM) continues; IDLE and DONE start over.
    open_frame = (state != S_ACCUM);

    zsum = (open_frame ? '0 : SW'(zeros_total)) + SW'(zeros_c);
    osum = (open_frame ? '0 : SW'(ones_total))  + SW'(ones_c);
    z_of = (zsum >= ACC_LIM);
    o_of = (osum >= ACC_LIM);

    wc_of  = !open_frame && (word_cnt == '1);
    wc_nxt = open_frame ? CNT_WIDTH'(1) : word_cnt + CNT_WIDTH'(1);

`ifdef ZERO_ONE_ACC_SAT_EN
    zt_nxt = z_of ? '1 : zsum[ACC_WIDTH-1:0];
    ot_nxt = o_of ? '1 : osum[ACC_WIDTH-1:0];
    if (wc_of) wc_nxt = '1;
`else
    zt_nxt = zsum[ACC_WIDTH-1:0];
    ot_nxt = osum[ACC_WIDTH-1:0];
`endif

    // A new frame starts with a clean flag; otherwise the flag is sticky.
    ovf_nxt = (open_frame ? 1'b0 : ovf) | z_of | o_of | wc_of;
  end

  // Output registers: word counts, totals, pulses and the sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      zeros       <= '0;
      ones        <= '0;
      zeros_total <= '0;
      ones_total  <= '0;
      word_cnt    <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
    end else if (clear) begin
      out_valid   <= 1'b0;
      zeros_total <= '0;
      ones_total  <= '0;
      word_cnt    <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
    end else if (in_valid) begin
      out_valid   <= 1'b1;
      zeros       <= zeros_c;
      ones        <= ones_c;
      zeros_total <= zt_nxt;
      ones_total  <= ot_nxt;
      word_cnt    <= wc_nxt;
      frame_done  <= frame_last;
      ovf         <= ovf_nxt;
    end else begin
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
    end
  end

endmodule
